cp0_regfile: RTL
================

Name: cp0_regfile

Overview:
- Coprocessor-0 register file for the MIPS pipeline.
- Consumes the one-hot-coded exception type, bad address and faulting PC produced by the exception arbitration stage.
- Updates Status/Cause/EPC/BadVAddr accordingly and returns status/cause/epc to that stage on the next cycle.
- Also serves MTC0/MFC0 and owns the Count/Compare timer and its interrupt.

Parameters:
PRID_VALUE, 32'h00004220, read-only PRId (reg 15) contents
CONFIG_VALUE, 32'h00008000, read-only Config (reg 16) contents

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous reset, active-low (rst==0 resets on the clock edge)
we  in  1  MTC0 write enable
waddr  in  5  MTC0 destination register number
raddr  in  5  MFC0 source register number
wdata  in  32  MTC0 data
int_hw  in  6  external hardware interrupt lines, level-sensitive
excepttype  in  32  exception code from arbitration stage, 0 = none
pc  in  32  address of the faulting instruction
is_delayslot  in  1  faulting instruction sits in a branch delay slot
badramaddr  in  32  faulting address for address-error exceptions
rdata  out  32  MFC0 read data, combinational from raddr
cp0status  out  32  Status (reg 12)
cp0cause  out  32  Cause (reg 13)
cp0epc  out  32  EPC (reg 14)
cp0count  out  32  Count (reg 9)
cp0compare  out  32  Compare (reg 11)
cp0badvaddr  out  32  BadVAddr (reg 8)
timer_int  out  1  timer interrupt pending

Behaviour:
- Reset (rst==0): BadVAddr=0, Count=0, Compare=0, Status=32'h00400000 (BEV=1), Cause=0, EPC=0, timer_int=0; internal count-toggle flop=0.
- Count:
  - Toggle flop flips every cycle; Count += 1 on cycles where toggle==1 (half clock rate), wrapping 32'hFFFFFFFF -> 0.
  - MTC0 to Count overrides the increment that cycle.
- Timer:
  - When Compare!=0 and Count==Compare (current values), timer_int<=1 next edge.
  - Stays set until an MTC0 to Compare, which clears it; that clear wins over a same-cycle match.
- Cause interrupt bits:
  - Every cycle Cause[15:10] <= {int_hw[5] | timer_int, int_hw[4:0]}.
  - Cause[30] (TI) <= timer_int.
  - Cause[9:8] are software-writable only.
- MTC0 writable fields (others ignore writes):
  - Status: 22 (BEV), 15:8 (IM), 1 (EXL), 0 (IE).
  - Cause: 9:8.
  - EPC, Compare, Count: full 32 bits.
  - Writes to 8/15/16 and unlisted numbers have no effect.
- Exception commit: excepttype is sampled each edge; the update is visible on outputs the following cycle.
- Codes 1, 4, 5, 8, 9, a, c (mapped ExcCode 0x00, 0x04, 0x05, 0x08, 0x09, 0x0A, 0x0C):
  - If Status.EXL==0: EPC <= is_delayslot ? pc-4 : pc; Cause[31] (BD) <= is_delayslot.
  - If Status.EXL==1: EPC and BD unchanged (nested exception).
  - Always: Status.EXL <= 1; Cause[6:2] <= ExcCode.
  - Codes 4 and 5 only: BadVAddr <= badramaddr.
- Code e (ERET): Status.EXL <= 0; nothing else changes.
- Any other value, including 0: no exception action.
- Simultaneous MTC0 and nonzero recognised excepttype: exception update applies; MTC0 is discarded entirely (including Compare clear and Count write).
- Count increment and the interrupt-bit sampling continue regardless.
- rdata:
  - Returns the current register value for raddr 8, 9, 11, 12, 13, 14; PRID_VALUE for 15; CONFIG_VALUE for 16; 0 otherwise.
  - No write-to-read bypass.
- Reset asserted mid-operation: all state returns to reset values on that edge regardless of we/excepttype.

Test Plan:
- Reset, then 10 idle cycles -> cp0count==5, cp0status==32'h00400000, timer_int==0.
- MTC0 Compare=8 after reset -> timer_int rises one cycle after Count==8, cp0cause[15]==1, cp0cause[30]==1. Then MTC0 Compare=0 -> timer_int==0 next cycle.
- excepttype=4, pc=32'hBFC00100, badramaddr=32'h00000003, is_delayslot=0, EXL=0 -> next cycle cp0epc==32'hBFC00100, cp0badvaddr==3, cp0cause[6:2]==4, cp0status[1]==1.
- With EXL already 1: excepttype=c, pc=32'h80000020, is_delayslot=1 -> EPC and BD unchanged, ExcCode==0x0C.
- Delay-slot syscall: excepttype=8, pc=32'h80000010, is_delayslot=1, EXL=0 -> cp0epc==32'h8000000C, cp0cause[31]==1. Then excepttype=e -> cp0status[1]==0.
- Same cycle MTC0 EPC=32'h12345678 and excepttype=9, pc=32'h80000040 -> cp0epc==32'h80000040.
- rst low mid-timer-count -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/cp0_regfile.sv
// MIPS coprocessor-0 register file: Status/Cause/EPC/BadVAddr exception state,
// MTC0/MFC0 access, and the Count/Compare timer with its interrupt.
module cp0_regfile #(
  parameter logic [31:0] PRID_VALUE   = 32'h00004220,
  parameter logic [31:0] CONFIG_VALUE = 32'h00008000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [4:0]  raddr,
  input  logic [31:0] wdata,
  input  logic [5:0]  int_hw,
  input  logic [31:0] excepttype,
  input  logic [31:0] pc,
  input  logic        is_delayslot,
  input  logic [31:0] badramaddr,
  output logic [31:0] rdata,
  output logic [31:0] cp0status,
  output logic [31:0] cp0cause,
  output logic [31:0] cp0epc,
  output logic [31:0] cp0count,
  output logic [31:0] cp0compare,
  output logic [31:0] cp0badvaddr,
  output logic        timer_int
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam logic [4:0] REG_CONFIG   = 5'd16;

  localparam logic [31:0] STATUS_RST  = 32'h0040_0000;
  // BEV, IM[7:0], EXL, IE
  localparam logic [31:0] STATUS_WMSK = 32'h0040_FF03;

  logic       toggle;
  logic       exc_hit;
  logic       exc_eret;
  logic       exc_addr;
  logic [4:0] exc_code;
  logic       wr;

  always_comb begin
    exc_hit  = 1'b1;
    exc_eret = 1'b0;
    exc_addr = 1'b0;
    exc_code = 5'h00;
    case (excepttype)
      32'h1: exc_code = 5'h00;
      32'h4: begin exc_code = 5'h04; exc_addr = 1'b1; end
      32'h5: begin exc_code = 5'h05; exc_addr = 1'b1; end
      32'h8: exc_code = 5'h08;
      32'h9: exc_code = 5'h09;
      32'ha: exc_code = 5'h0A;
      32'hc: exc_code = 5'h0C;
      32'he: begin exc_hit = 1'b0; exc_eret = 1'b1; end
      default: exc_hit = 1'b0;
    endcase
  end

  // An exception or ERET in the same cycle swallows the MTC0 completely.
  assign wr = we & ~exc_hit & ~exc_eret;

  always_ff @(posedge clk) begin
    if (!rst) begin
      toggle      <= 1'b0;
      cp0badvaddr <= '0;
      cp0count    <= '0;
      cp0compare  <= '0;
      cp0status   <= STATUS_RST;
      cp0cause    <= '0;
      cp0epc      <= '0;
      timer_int   <= 1'b0;
    end else begin
      toggle <= ~toggle;
      if (wr && waddr == REG_COUNT) cp0count <= wdata;
      else if (toggle)              cp0count <= cp0count + 32'd1;

      // Compare write clears the pending timer even on a coincident match.
      if (wr && waddr == REG_COMPARE) begin
        cp0compare <= wdata;
        timer_int  <= 1'b0;
      end else if (cp0compare != '0 && cp0count == cp0compare) begin
        timer_int  <= 1'b1;
      end

      cp0cause[15:10] <= {int_hw[5] | timer_int, int_hw[4:0]};
      cp0cause[30]    <= timer_int;

      if (exc_hit) begin
        if (!cp0status[1]) begin
          cp0epc       <= is_delayslot ? pc - 32'd4 : pc;
          cp0cause[31] <= is_delayslot;
        end
        cp0status[1]   <= 1'b1;
        cp0cause[6:2]  <= exc_code;
        if (exc_addr) cp0badvaddr <= badramaddr;
      end else if (exc_eret) begin
        cp0status[1] <= 1'b0;
      end else if (wr) begin
        case (waddr)
          REG_STATUS: cp0status     <= (cp0status & ~STATUS_WMSK) | (wdata & STATUS_WMSK);
          REG_CAUSE:  cp0cause[9:8] <= wdata[9:8];
          REG_EPC:    cp0epc        <= wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    case (raddr)
      REG_BADVADDR: rdata = cp0badvaddr;
      REG_COUNT:    rdata = cp0count;
      REG_COMPARE:  rdata = cp0compare;
      REG_STATUS:   rdata = cp0status;
      REG_CAUSE:    rdata = cp0cause;
      REG_EPC:      rdata = cp0epc;
      REG_PRID:     rdata = PRID_VALUE;
      REG_CONFIG:   rdata = CONFIG_VALUE;
      default:      rdata = '0;
    endcase
  end

endmodule
